nanorv32_apb_bridge: RTL
========================

Name: nanorv32_apb_bridge

Overview:
Downstream of the TCM arbiter's data side: converts CPU data-interface requests that fall in the peripheral window into APB3 master transfers. Returns read data to the CPU using the same early-ready handshake the TCM path uses. Provides wait-state handling, a bus timeout watchdog and a sticky error flag. Drives a single APB segment (UART, timers, GPIO).

Parameters:
PERIPH_BASE, 32'h0001_0000, base address of the peripheral window (aligned to 2^PERIPH_AW)
PERIPH_AW, 12, byte-address width of the window; paddr width
TIMEOUT, 255, max ACCESS cycles without pready before abort (1..255)
TIMEOUT_RDATA, 32'hDEAD_BEEF, read data returned on timeout

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
cpu_dataif_addr  in  32  CPU byte address
cpu_dataif_wdata  in  32  write data
cpu_dataif_bytesel  in  4  byte enables
cpu_dataif_we  in  1  1=write, 0=read
cpu_dataif_req  in  1  request; held stable until early_ready
periph_cpu_rdata  out  32  read data, registered
periph_cpu_early_ready  out  1  completion; rdata valid the following cycle
periph_hit  out  1  combinational: addr inside window (used by arbiter mux)
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
paddr  out  PERIPH_AW  APB address, word aligned ([1:0]=0)
pwdata  out  32  APB write data
pstrb  out  4  APB strobes (bytesel on writes, 0 on reads)
prdata  in  32  APB read data
pready  in  1  APB ready
pslverr  in  1  APB slave error
err_sticky  out  1  set on pslverr or timeout
err_clr  in  1  synchronous clear of err_sticky

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0 (psel, penable, pwrite, paddr, pwdata, pstrb, periph_cpu_rdata, early_ready, err_sticky); timeout counter 0.
- periph_hit = (cpu_dataif_addr[31:PERIPH_AW] == PERIPH_BASE[31:PERIPH_AW]). Out-of-window requests are ignored; the bridge stays IDLE.
- FSM IDLE -> SETUP -> ACCESS -> IDLE:
  - IDLE: on req & hit, register addr/wdata/strb/we. Next state SETUP.
  - SETUP: psel=1, penable=0. Next state ACCESS.
  - ACCESS: psel=1, penable=1, counter increments each cycle.
    - pready=1: early_ready=1 (combinational, this cycle). Capture prdata on reads (pslverr forces 0). Next state IDLE.
    - counter reaches TIMEOUT without pready: early_ready=1, rdata=TIMEOUT_RDATA, err_sticky set, psel/penable dropped. Next state IDLE.
- Minimum latency: request seen in IDLE at cycle N -> early_ready at N+2 -> rdata valid at N+3.
- A write's early_ready also releases the CPU; periph_cpu_rdata is unchanged by writes.
- Back-to-back: the bridge is in IDLE the cycle after completion. If req & hit is asserted then, it is a new transfer. No pipelining; one outstanding transfer.
- APB outputs are held stable from SETUP through the end of ACCESS. paddr/pwdata/pwrite/pstrb retain their last values in IDLE; psel=penable=0.
- err_sticky: set has priority over err_clr in the same cycle.
- Counter is 8-bit and saturates; it clears on entering SETUP.
- Reset mid-transfer: immediate return to IDLE with all outputs cleared. The APB slave sees psel drop.

Decomposition:
- Shared package nanorv32_periph_pkg:
  - FSM state encodings (IDLE=2'b00, SETUP=2'b01, ACCESS=2'b10)
  - APB strobe width
  - default PERIPH_BASE/PERIPH_AW constants, reused by the arbiter's decode
- One sub-module: nanorv32_apb_wdog (load/enable/expire counter). The rest is a single FSM module.

Test Plan:
- Read 0x0001_0004, slave pready=1 at first ACCESS, prdata=0x1234_5678 -> paddr=0x004, pwrite=0, early_ready 2 cycles after req, rdata=0x1234_5678 one cycle later.
- Write 0x0001_0010, wdata=0xA5A5_0000, bytesel=4'b1100, slave inserts 3 wait states -> pstrb=4'b1100 and pwdata held 4 ACCESS cycles; early_ready on the pready cycle only.
- Read with slave never ready, TIMEOUT=4 -> early_ready after 4 ACCESS cycles, rdata=0xDEAD_BEEF, err_sticky=1. err_clr=1 -> err_sticky=0 next cycle.
- pslverr=1 with pready on a read -> rdata=0, err_sticky=1. Same-cycle set and err_clr -> err_sticky stays 1.
- Request at 0x0000_8000 (outside window) -> periph_hit=0, psel never asserts, no early_ready.
- rst_n pulled low during ACCESS -> psel/penable/early_ready 0 immediately. After release, a new read completes normally.

Source files
------------

// File: rtl/nanorv32_periph_pkg.sv
// Shared peripheral-side definitions: bridge FSM encodings, APB strobe width
// and the default peripheral window used by both the bridge and the arbiter decode.
package nanorv32_periph_pkg;

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_SETUP  = 2'b01;
    localparam logic [1:0] ST_ACCESS = 2'b10;

    localparam int APB_STRB_W = 4;

    localparam logic [31:0] DEFAULT_PERIPH_BASE = 32'h0001_0000;
    localparam int          DEFAULT_PERIPH_AW   = 12;

    typedef logic [APB_STRB_W-1:0] apb_strb_t;

endpackage

// File: rtl/nanorv32_apb_bridge_if.sv
// APB3 segment signals between the bridge (master) and the peripherals (slave).
interface nanorv32_apb_bridge_if
    import nanorv32_periph_pkg::*;
#(
    parameter int AW = DEFAULT_PERIPH_AW
);

    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [31:0]   pwdata;
    apb_strb_t     pstrb;
    logic [31:0]   prdata;
    logic          pready;
    logic          pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/nanorv32_apb_wdog.sv
// Saturating 8-bit ACCESS-cycle counter; expire flags the cycle in which the
// running count reaches TIMEOUT.
module nanorv32_apb_wdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic enable,
    output logic expire
);

    logic [7:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 8'd0;
        end else if (load) begin
            count <= 8'd0;
        end else if (enable && count != 8'hFF) begin
            count <= count + 8'd1;
        end
    end

    // count holds completed ACCESS cycles, so the current one is count+1
    assign expire = enable && (count >= 8'(TIMEOUT - 1));

endmodule

// File: rtl/nanorv32_apb_bridge.sv
// CPU data-interface to APB3 master bridge for the peripheral window, with
// early-ready completion, timeout abort and a sticky error flag.
module nanorv32_apb_bridge
    import nanorv32_periph_pkg::*;
#(
    parameter logic [31:0] PERIPH_BASE   = DEFAULT_PERIPH_BASE,
    parameter int          PERIPH_AW     = DEFAULT_PERIPH_AW,
    parameter int          TIMEOUT       = 255,
    parameter logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] cpu_dataif_addr,
    input  logic [31:0] cpu_dataif_wdata,
    input  logic [3:0]  cpu_dataif_bytesel,
    input  logic        cpu_dataif_we,
    input  logic        cpu_dataif_req,
    output logic [31:0] periph_cpu_rdata,
    output logic        periph_cpu_early_ready,
    output logic        periph_hit,
    output logic        err_sticky,
    input  logic        err_clr,
    nanorv32_apb_bridge_if.master apb
);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       start;
    logic       in_access;
    logic       done_ok;
    logic       abort;
    logic       expire;
    logic       unused_addr_lsbs;

    assign unused_addr_lsbs = ^cpu_dataif_addr[1:0];

    assign periph_hit = (cpu_dataif_addr[31:PERIPH_AW] == PERIPH_BASE[31:PERIPH_AW]);
    assign start      = (state == ST_IDLE) && cpu_dataif_req && periph_hit;
    assign in_access  = (state == ST_ACCESS);
    assign done_ok    = in_access && apb.pready;
    assign abort      = in_access && !apb.pready && expire;

    assign periph_cpu_early_ready = done_ok || abort;
    assign apb.psel    = (state == ST_SETUP) || in_access;
    assign apb.penable = in_access;

    always_comb begin
        state_nxt = ST_IDLE;
        case (state)
            ST_IDLE:   state_nxt = start ? ST_SETUP : ST_IDLE;
            ST_SETUP:  state_nxt = ST_ACCESS;
            ST_ACCESS: state_nxt = (done_ok || abort) ? ST_IDLE : ST_ACCESS;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Request is latched once; APB outputs then hold through SETUP/ACCESS and linger in IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            apb.paddr  <= '0;
            apb.pwdata <= 32'd0;
            apb.pwrite <= 1'b0;
            apb.pstrb  <= '0;
        end else if (start) begin
            apb.paddr  <= {cpu_dataif_addr[PERIPH_AW-1:2], 2'b00};
            apb.pwdata <= cpu_dataif_wdata;
            apb.pwrite <= cpu_dataif_we;
            apb.pstrb  <= cpu_dataif_we ? cpu_dataif_bytesel : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            periph_cpu_rdata <= 32'd0;
        end else if (done_ok && !apb.pwrite) begin
            periph_cpu_rdata <= apb.pslverr ? 32'd0 : apb.prdata;
        end else if (abort && !apb.pwrite) begin
            periph_cpu_rdata <= TIMEOUT_RDATA;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sticky <= 1'b0;
        end else if ((done_ok && apb.pslverr) || abort) begin
            err_sticky <= 1'b1;
        end else if (err_clr) begin
            err_sticky <= 1'b0;
        end
    end

    nanorv32_apb_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (start),
        .enable (in_access),
        .expire (expire)
    );

endmodule
